// File: rtl/vec_arb_pkg.sv
// Shared types and the rotate-priority pick helper for the Dpath arbiters.
package vec_arb_pkg;

    typedef enum logic [0:0] {IDLE, LOCKED} arb_state_t;

    // Widest requester set any arbiter built on rr_pick may use
    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned PICK_W  = 4;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // First set bit of val at or after ptr, wrapping modulo n (n <= MAX_REQ, ptr < n)
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] val,
                                      input logic [PICK_W-1:0]  ptr,
                                      input int unsigned        n);
        pick_t           r;
        logic [PICK_W:0] cand;
        r = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            cand = {1'b0, ptr} + (PICK_W+1)'(k);
            // Explicit wrap so non-power-of-two n works
            if (cand >= (PICK_W+1)'(n)) begin
                cand = cand - (PICK_W+1)'(n);
            end
            if (k < n && !r.found && val[cand[PICK_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = cand[PICK_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-priority encoder: first valid index starting at ptr.
module rr_priority_pick
    import vec_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] val,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    logic [MAX_REQ-1:0] val_ext;
    logic [PICK_W-1:0]  ptr_ext;
    pick_t              pick;

    // Widen to the helper's fixed size and pick the winner
    always_comb begin
        val_ext                = '0;
        val_ext[NUM_REQ-1:0]   = val;
        ptr_ext                = '0;
        ptr_ext[ID_W-1:0]      = ptr;
        pick                   = rr_pick(val_ext, ptr_ext, NUM_REQ);
        idx                    = pick.idx[ID_W-1:0];
        found                  = pick.found;
    end

endmodule

// File: rtl/vec_req_arbiter.sv
// Round-robin val/rdy arbiter with burst locking and source-id tagging.
module vec_req_arbiter
    import vec_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned WIDTH     = 8,
    parameter  int unsigned MAX_BURST = 16,
    localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ*WIDTH-1:0] req_msg,
    input  logic [NUM_REQ-1:0]       req_val,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_rdy,
    output logic [WIDTH-1:0]         send_msg,
    output logic [ID_W-1:0]          send_id,
    output logic                     send_last,
    output logic                     send_val,
    input  logic                     send_rdy,
    output logic [NUM_REQ-1:0]       grant_oh,
    output logic                     busy,
    output logic                     burst_err
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             burst_err_q, burst_err_d;

    logic [ID_W-1:0]  pick_idx;
    logic             pick_found;
    logic [ID_W-1:0]  grant_idx;
    logic             have_grant;
    logic [ID_W-1:0]  next_ptr;
    logic             xfer;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .val   (req_val),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Grant selection and forwarding mux
    always_comb begin
        grant_oh   = '0;
        send_msg   = '0;
        send_id    = '0;
        send_last  = 1'b0;
        if (state_q == LOCKED) begin
            grant_idx  = owner_q;
            have_grant = 1'b1;
            send_val   = req_val[owner_q];
        end else begin
            grant_idx  = pick_idx;
            have_grant = pick_found;
            send_val   = pick_found;
        end
        if (have_grant) begin
            grant_oh[grant_idx] = 1'b1;
            send_msg            = req_msg[grant_idx*WIDTH +: WIDTH];
            send_id             = grant_idx;
            send_last           = req_last[grant_idx];
        end
        req_rdy   = grant_oh & {NUM_REQ{send_rdy}};
        xfer      = send_val && send_rdy;
        next_ptr  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        busy      = (state_q == LOCKED);
        burst_err = burst_err_q;
    end

    // Next-state: burst locking, pointer advance, burst-limit release
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        beat_cnt_d  = beat_cnt_q;
        burst_err_d = burst_err_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    // A single-beat limit means every beat closes its burst
                    if (send_last || MAX_BURST == 1) begin
                        rr_ptr_d = next_ptr;
                        if (!send_last) begin
                            burst_err_d = 1'b1;
                        end
                    end else begin
                        state_d    = LOCKED;
                        owner_d    = grant_idx;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (xfer) begin
                    if (send_last) begin
                        state_d    = IDLE;
                        rr_ptr_d   = next_ptr;
                        beat_cnt_d = '0;
                    end else if (beat_cnt_q + CNT_W'(1) == CNT_W'(MAX_BURST)) begin
                        state_d     = IDLE;
                        rr_ptr_d    = next_ptr;
                        beat_cnt_d  = '0;
                        burst_err_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration state registers, asynchronously cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            beat_cnt_q  <= '0;
            burst_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_err_q <= burst_err_d;
        end
    end

endmodule

// File: tb/tb_vec_req_arbiter.sv
// Directed self-checking bench for vec_req_arbiter (NUM_REQ=4, WIDTH=8, MAX_BURST=4).
module tb_vec_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req_msg;
    logic [3:0]  req_val;
    logic [3:0]  req_last;
    logic [3:0]  req_rdy;
    logic [7:0]  send_msg;
    logic [1:0]  send_id;
    logic        send_last;
    logic        send_val;
    logic        send_rdy;
    logic [3:0]  grant_oh;
    logic        busy;
    logic        burst_err;

    int n_cmp = 0;
    int n_err = 0;

    vec_req_arbiter #(
        .NUM_REQ   (4),
        .WIDTH     (8),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_msg   (req_msg),
        .req_val   (req_val),
        .req_last  (req_last),
        .req_rdy   (req_rdy),
        .send_msg  (send_msg),
        .send_id   (send_id),
        .send_last (send_last),
        .send_val  (send_val),
        .send_rdy  (send_rdy),
        .grant_oh  (grant_oh),
        .busy      (busy),
        .burst_err (burst_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        req_val  = '0;
        req_last = '0;
        send_rdy = 1'b0;
        for (int i = 0; i < 4; i++) req_msg[i*8 +: 8] = 8'hA0 + 8'(i);

        // Reset state
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(burst_err), 0);
        chk("rst_val", 32'(send_val), 0);
        chk("rst_grant", 32'(grant_oh), 0);
        chk("rst_msg", 32'(send_msg), 0);
        tick();
        reset = 1'b0;

        // Fairness: all valid, single-beat
        req_val  = 4'b1111;
        req_last = 4'b1111;
        send_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_id", 32'(send_id), 32'(k % 4));
            chk("rr_msg", 32'(send_msg), 32'(8'hA0 + 8'(k % 4)));
            chk("rr_grant", 32'(grant_oh), 32'(4'b0001 << (k % 4)));
            chk("rr_rdy", 32'(req_rdy), 32'(4'b0001 << (k % 4)));
            tick();
        end
        chk("rr_err", 32'(burst_err), 0);

        // Three-beat burst from requester 2, requester 0 waits
        req_val  = 4'b0100;
        req_last = 4'b0000;
        #1;
        chk("b2_id1", 32'(send_id), 2);
        chk("b2_busy1", 32'(busy), 0);
        tick();
        req_val = 4'b0101;
        #1;
        chk("b2_id2", 32'(send_id), 2);
        chk("b2_busy2", 32'(busy), 1);
        chk("b2_rdy2", 32'(req_rdy), 32'(4'b0100));
        tick();
        req_last = 4'b0100;
        #1;
        chk("b2_id3", 32'(send_id), 2);
        chk("b2_busy3", 32'(busy), 1);
        chk("b2_last3", 32'(send_last), 1);
        chk("b2_rdy3", 32'(req_rdy), 32'(4'b0100));
        tick();
        chk("b2_ptr", 32'(dut.rr_ptr_q), 3);
        req_val  = 4'b0001;
        req_last = 4'b0001;
        #1;
        chk("b2_next", 32'(send_id), 0);
        chk("b2_idle", 32'(busy), 0);
        tick();

        // Owner 1 locked, drops val for two cycles while requester 3 waits
        req_val  = 4'b0010;
        req_last = 4'b0000;
        #1;
        chk("gap_id", 32'(send_id), 1);
        tick();
        req_val = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("gap_val", 32'(send_val), 0);
            chk("gap_grant", 32'(grant_oh), 32'(4'b0010));
            chk("gap_rdy", 32'(req_rdy), 32'(4'b0010));
            tick();
        end
        req_val  = 4'b1010;
        req_last = 4'b1010;
        #1;
        chk("gap_resume_val", 32'(send_val), 1);
        chk("gap_resume_id", 32'(send_id), 1);
        tick();
        req_val = 4'b1000;
        #1;
        chk("gap_after", 32'(send_id), 3);
        chk("gap_after_busy", 32'(busy), 0);
        tick();

        // Backpressure with pointer at 0
        req_val  = 4'b1001;
        req_last = 4'b1111;
        send_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_val", 32'(send_val), 1);
            chk("bp_id", 32'(send_id), 0);
            chk("bp_rdy", 32'(req_rdy), 0);
            tick();
        end
        send_rdy = 1'b1;
        #1;
        chk("bp_go0", 32'(send_id), 0);
        tick();
        #1;
        chk("bp_go3", 32'(send_id), 3);
        tick();

        // Burst limit: requester 0 never sends last
        req_val  = 4'b0001;
        req_last = 4'b0000;
        #1;
        chk("lim_id1", 32'(send_id), 0);
        tick();
        req_val  = 4'b0011;
        req_last = 4'b0010;
        for (int k = 2; k <= 4; k++) begin
            #1;
            chk("lim_id", 32'(send_id), 0);
            chk("lim_busy", 32'(busy), 1);
            chk("lim_rdy1", 32'(req_rdy[1]), 0);
            tick();
        end
        chk("lim_idle", 32'(busy), 0);
        chk("lim_err", 32'(burst_err), 1);
        #1;
        chk("lim_5th", 32'(send_id), 1);
        tick();
        chk("lim_err_sticky", 32'(burst_err), 1);

        // Reset mid-burst: owner 2, three beats in
        req_val  = 4'b0100;
        req_last = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mid_id", 32'(send_id), 2);
            tick();
        end
        chk("mid_busy", 32'(busy), 1);
        chk("mid_cnt", 32'(dut.beat_cnt_q), 3);
        req_val = 4'b0110;
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_err", 32'(burst_err), 0);
        chk("mid_rst_id", 32'(send_id), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_after_id", 32'(send_id), 1);
        chk("mid_after_grant", 32'(grant_oh), 32'(4'b0010));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vec_req_arbiter.md
Name: vec_req_arbiter

Overview:
- Round-robin arbiter that shares one val/rdy queue input among NUM_REQ requesters, such as vector lane writeback ports and the scalar command port, in the Dpath.
- Each beat forwarded to the queue carries the winner's source id.
- Supports multi-beat bursts: the grant is locked to one requester until its last beat, with a burst-length limit.
- Zero-latency combinational forwarding; all arbitration state is sequential.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 8, message width in bits.
- MAX_BURST, 16, maximum beats per locked burst before forced release (>=1).
- ID_W, $clog2(NUM_REQ), localparam, source-id width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_msg  in  NUM_REQ*WIDTH  requester messages; requester i occupies bits [i*WIDTH +: WIDTH]
- req_val  in  NUM_REQ  per-requester valid
- req_last  in  NUM_REQ  per-requester last-beat-of-burst flag
- req_rdy  out  NUM_REQ  per-requester ready
- send_msg  out  WIDTH  forwarded message (to queue recv_msg)
- send_id  out  ID_W  index of the granted requester
- send_last  out  1  forwarded last flag
- send_val  out  1  forwarded valid (to queue recv_val)
- send_rdy  in  1  downstream ready (from queue recv_rdy)
- grant_oh  out  NUM_REQ  one-hot current grant (zero when there is no grant)
- busy  out  1  high in LOCKED state
- burst_err  out  1  sticky flag: a burst hit MAX_BURST without a last beat

Behaviour:
- Reset is asynchronous and active-high on clk. Reset values:
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, burst_err=0.
  - Outputs are then purely combinational from req_* with IDLE state.
- Transfer: a beat transfers on a cycle where send_val && send_rdy.
- Output rules:
  - req_rdy[i] = grant_oh[i] && send_rdy.
  - send_val never depends on send_rdy.
  - send_msg, send_id and send_last are muxed from the granted requester. When there is no grant they are 0.
- IDLE state:
  - Winner is the first i with req_val[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - grant_oh = onehot(winner) and send_val=1 if any req_val is set; otherwise grant_oh=0 and send_val=0.
  - Transfer with last=1: stay IDLE, rr_ptr <= (winner+1) mod NUM_REQ.
  - Transfer with last=0: go to LOCKED, owner <= winner, beat_cnt <= 1.
  - No transfer (send_rdy=0): no state change. The winner may change next cycle if req_val changes; requesters must hold val once asserted.
- LOCKED state:
  - grant_oh = onehot(owner) and send_val = req_val[owner]. Other requesters see req_rdy=0.
  - The grant is held even while the owner's val is low.
  - Transfer with last=1: go to IDLE, rr_ptr <= (owner+1) mod NUM_REQ, beat_cnt <= 0.
  - Transfer with last=0 and beat_cnt+1 == MAX_BURST: forced release. Go to IDLE, rr_ptr <= owner+1 mod NUM_REQ, burst_err <= 1.
  - Transfer otherwise: beat_cnt <= beat_cnt+1.
- beat_cnt width is $clog2(MAX_BURST+1).
- With MAX_BURST=1, every beat is treated as last and LOCKED is never entered. burst_err is set on any last=0 beat.
- Wrap-around: the pointer and owner advance from NUM_REQ-1 to 0. NUM_REQ need not be a power of 2; use explicit compare, not truncation.
- Reset mid-burst: return to IDLE immediately with ptr 0. Any partial burst downstream is the consumer's concern.
- burst_err clears only on reset.
- Fairness: with all requesters continuously valid and single-beat, grants rotate 0,1,2,3,0,...

Decomposition:
- Package vec_arb_pkg holds:
  - arb_state_t enum {IDLE, LOCKED}.
  - function rr_pick(val, ptr), returning winner index and a found flag.
- One sub-module, rr_priority_pick: combinational rotate-priority encoder taking val and ptr, producing idx and found. It is reusable by other Dpath arbiters.
- The top module holds the FSM, counters and mux.

Test Plan:
- Reset, then req_val=4'b1111, all last=1, send_rdy=1 for 8 cycles -> send_id sequence 0,1,2,3,0,1,2,3; burst_err=0.
- req_val=4'b0100, req_last=0 for 2 beats then last=1 on the 3rd; meanwhile req_val[0]=1 -> send_id=2 for 3 beats, busy=1 for beats 2-3, req_rdy[0]=0 throughout. The next grant goes to requester 0 and rr_ptr becomes 3.
- Owner 1 locked, req_val[1] drops for 2 cycles while req_val[3]=1 -> send_val=0, grant_oh=4'b0010, req_rdy[3]=0. The burst resumes when val[1] returns.
- send_rdy=0 for 3 cycles with req_val=4'b1001, ptr=0 -> send_val=1, send_id=0 held, no state change. Releasing send_rdy transfers id 0, then id 3.
- MAX_BURST=4, requester 0 sends 6 beats all last=0 -> after the 4th transfer state=IDLE and burst_err=1. With requester 1 valid, the 5th beat goes to id 1.
- Assert reset asynchronously mid-burst (owner=2, beat_cnt=3) -> busy=0 and burst_err=0 immediately. Next grant is to the lowest valid index from ptr 0.
